// File: rtl/irig_frame_sequencer.sv
// IRIG-B frame sequencer: locks to Pr/P markers and emits BCD bit writes into the time register bank.
// Write strobe and field address are registered, valid one cycle after the symbol strobe.
module irig_frame_sequencer (
  input  logic       clk,
  input  logic       hrd_rst,
  input  logic       en,
  input  logic       sym_valid,
  input  logic [2:0] irig_data,
  output logic       wr_en,
  output logic [3:0] dir,
  output logic [1:0] wr_pos,
  output logic       wr_bit,
  output logic [6:0] bit_idx,
  output logic       in_frame,
  output logic       frame_done,
  output logic       err,
  output logic [7:0] frame_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HUNT = 3'd1,
    SYNC = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [2:0] CODE_MARK = 3'b111;
  localparam logic [2:0] CODE_ONE  = 3'b011;
  localparam logic [2:0] CODE_ZERO = 3'b001;
  localparam logic [3:0] DIR_NONE  = 4'b1111;

  state_t     cur, nxt;
  logic       is_mark, is_data, at_mark;
  logic       fld_hit;
  logic [3:0] fld_dir;
  logic [6:0] fld_base, fld_off;

  logic       wr_en_nxt, wr_bit_nxt;
  logic [3:0] dir_nxt;
  logic [1:0] wr_pos_nxt;
  logic [6:0] bit_idx_nxt;
  logic [7:0] frame_cnt_nxt;

  assign state      = cur;
  assign in_frame   = (cur == DATA);
  assign frame_done = (cur == DONE);
  assign err        = (cur == ERR);

  assign is_mark = (irig_data == CODE_MARK);
  assign is_data = (irig_data == CODE_ONE) || (irig_data == CODE_ZERO);
  assign at_mark = ((bit_idx % 7'd10) == 7'd9);

  // Frame position -> register field; offset from the field start is the bit weight.
  always_comb begin
    fld_hit  = 1'b1;
    fld_dir  = 4'd0;
    fld_base = 7'd0;
    case (bit_idx) inside
      [7'd1:7'd4]:   begin fld_dir = 4'd0; fld_base = 7'd1;  end
      [7'd6:7'd8]:   begin fld_dir = 4'd1; fld_base = 7'd6;  end
      [7'd10:7'd13]: begin fld_dir = 4'd2; fld_base = 7'd10; end
      [7'd15:7'd17]: begin fld_dir = 4'd3; fld_base = 7'd15; end
      [7'd20:7'd23]: begin fld_dir = 4'd4; fld_base = 7'd20; end
      [7'd25:7'd26]: begin fld_dir = 4'd5; fld_base = 7'd25; end
      [7'd30:7'd33]: begin fld_dir = 4'd6; fld_base = 7'd30; end
      [7'd35:7'd38]: begin fld_dir = 4'd7; fld_base = 7'd35; end
      [7'd40:7'd41]: begin fld_dir = 4'd8; fld_base = 7'd40; end
      default:       fld_hit = 1'b0;
    endcase
    fld_off = bit_idx - fld_base;
  end

  always_ff @(posedge clk) begin
    if (hrd_rst) cur <= IDLE;
    else         cur <= nxt;
  end

  always_comb begin
    nxt           = cur;
    bit_idx_nxt   = bit_idx;
    frame_cnt_nxt = frame_cnt;
    wr_en_nxt     = 1'b0;
    dir_nxt       = dir;
    wr_pos_nxt    = wr_pos;
    wr_bit_nxt    = wr_bit;

    if (!en) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE: nxt = HUNT;
        HUNT: if (sym_valid && is_mark) nxt = SYNC;
        // DONE behaves as SYNC so the next frame's Pr keeps lock.
        SYNC, DONE: begin
          nxt = SYNC;
          if (sym_valid) begin
            if (is_mark) begin
              nxt         = DATA;
              bit_idx_nxt = 7'd1;
            end else begin
              nxt = HUNT;
            end
          end
        end
        DATA: begin
          if (sym_valid) begin
            if (at_mark) begin
              if (!is_mark) begin
                nxt = ERR;
              end else if (bit_idx == 7'd99) begin
                nxt           = DONE;
                frame_cnt_nxt = frame_cnt + 8'd1;
              end else begin
                bit_idx_nxt = bit_idx + 7'd1;
              end
            end else if (!is_data) begin
              nxt = ERR;
            end else begin
              bit_idx_nxt = bit_idx + 7'd1;
              if (fld_hit) begin
                wr_en_nxt  = 1'b1;
                dir_nxt    = fld_dir;
                wr_pos_nxt = fld_off[1:0];
                wr_bit_nxt = (irig_data == CODE_ONE);
              end
            end
          end
        end
        ERR: begin
          nxt = HUNT;
          if (sym_valid && is_mark) nxt = SYNC;
        end
        default: nxt = IDLE;
      endcase
    end

    if (nxt != DATA) bit_idx_nxt = 7'd0;
    if ((nxt == IDLE) || (nxt == HUNT) || (nxt == ERR)) dir_nxt = DIR_NONE;
  end

  always_ff @(posedge clk) begin
    if (hrd_rst) begin
      wr_en     <= 1'b0;
      dir       <= DIR_NONE;
      wr_pos    <= 2'd0;
      wr_bit    <= 1'b0;
      bit_idx   <= 7'd0;
      frame_cnt <= 8'd0;
    end else begin
      wr_en     <= wr_en_nxt;
      dir       <= dir_nxt;
      wr_pos    <= wr_pos_nxt;
      wr_bit    <= wr_bit_nxt;
      bit_idx   <= bit_idx_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Directed bench for irig_frame_sequencer: lock, decode, error, reset, enable and wrap scenarios.
module tb_irig_frame_sequencer;

  logic       clk = 1'b0;
  logic       hrd_rst, en, sym_valid;
  logic [2:0] irig_data;
  logic       wr_en, wr_bit, in_frame, frame_done, err;
  logic [3:0] dir;
  logic [1:0] wr_pos;
  logic [6:0] bit_idx;
  logic [7:0] frame_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  irig_frame_sequencer dut (
    .clk(clk), .hrd_rst(hrd_rst), .en(en), .sym_valid(sym_valid), .irig_data(irig_data),
    .wr_en(wr_en), .dir(dir), .wr_pos(wr_pos), .wr_bit(wr_bit), .bit_idx(bit_idx),
    .in_frame(in_frame), .frame_done(frame_done), .err(err), .frame_cnt(frame_cnt),
    .state(state)
  );

  localparam int T_SEC = 56;
  localparam int T_MIN = 34;
  localparam int T_HR  = 12;
  localparam int T_DAY = 123;

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, stray = 0;
  int w0, d0, e0;
  logic [3:0] regs [9];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference encoding of the time constants into the 100-position frame.
  function automatic logic [2:0] sym_at(input int p);
    int st[9], w[9], val[9];
    st  = '{1, 6, 10, 15, 20, 25, 30, 35, 40};
    w   = '{4, 3, 4, 3, 4, 2, 4, 4, 2};
    val = '{T_SEC % 10, T_SEC / 10, T_MIN % 10, T_MIN / 10, T_HR % 10, T_HR / 10,
            T_DAY % 10, (T_DAY / 10) % 10, T_DAY / 100};
    if (p == 0 || (p % 10) == 9) return 3'b111;
    for (int f = 0; f < 9; f++)
      if (p >= st[f] && p < st[f] + w[f])
        return (((val[f] >> (p - st[f])) & 1) != 0) ? 3'b011 : 3'b001;
    return 3'b001;
  endfunction

  // One idle cycle, one strobe cycle; returns at the negedge where the registered response is visible.
  task automatic send_sym(input logic [2:0] c);
    @(negedge clk);
    if (wr_en || err || frame_done) stray++;
    sym_valid = 1'b1;
    irig_data = c;
    @(negedge clk);
    sym_valid = 1'b0;
    irig_data = 3'b000;
    if (wr_en) begin
      wr_cnt++;
      if (int'(dir) < 9) regs[int'(dir)][wr_pos] = wr_bit;
    end
    if (err) err_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) send_sym(sym_at(p));
  endtask

  initial begin
    hrd_rst   = 1'b1;
    en        = 1'b1;
    sym_valid = 1'b0;
    irig_data = 3'b000;
    for (int f = 0; f < 9; f++) regs[f] = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_dir", dir, 15);
    chk("rst_wr_pos", wr_pos, 0);
    chk("rst_wr_bit", wr_bit, 0);
    chk("rst_bit_idx", bit_idx, 0);
    chk("rst_in_frame", in_frame, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_state", state, 0);

    hrd_rst = 1'b0;
    @(negedge clk);
    chk("idle_to_hunt", state, 1);
    chk("hunt_dir", dir, 15);

    // Full frame 12:34:56 day 123
    send_sym(3'b111);
    chk("sync_state", state, 2);
    send_range(0, 0);
    chk("pr_state", state, 3);
    chk("pr_bit_idx", bit_idx, 1);
    chk("pr_in_frame", in_frame, 1);
    send_range(1, 1);
    send_sym(sym_at(2));
    chk("pos2_wr_en", wr_en, 1);
    chk("pos2_dir", dir, 0);
    chk("pos2_wr_pos", wr_pos, 1);
    chk("pos2_wr_bit", wr_bit, 1);
    send_range(3, 98);
    send_sym(sym_at(99));
    chk("p0_frame_done", frame_done, 1);
    chk("p0_state", state, 4);
    chk("p0_frame_cnt", frame_cnt, 1);
    chk("p0_bit_idx", bit_idx, 0);
    @(negedge clk);
    chk("done_to_sync", state, 2);
    chk("done_pulse_len", frame_done, 0);
    chk("frame_writes", wr_cnt, 30);
    chk("sec_units", regs[0], 6);
    chk("sec_tens", regs[1], 5);
    chk("min_units", regs[2], 4);
    chk("min_tens", regs[3], 3);
    chk("hr_units", regs[4], 2);
    chk("hr_tens", regs[5], 1);
    chk("day_units", regs[6], 3);
    chk("day_tens", regs[7], 2);
    chk("day_hundreds", regs[8], 1);

    // Zero code where P2 is expected
    send_range(0, 18);
    send_sym(3'b001);
    chk("p2_err", err, 1);
    chk("p2_state", state, 5);
    chk("p2_bit_idx", bit_idx, 0);
    chk("p2_frame_cnt", frame_cnt, 1);
    @(negedge clk);
    chk("err_to_hunt", state, 1);
    chk("err_pulse_len", err, 0);
    w0 = wr_cnt;
    send_range(20, 23);
    chk("hunt_no_writes", wr_cnt - w0, 0);
    chk("hunt_dir_idle", dir, 15);
    chk("hunt_stays", state, 1);

    // Invalid code 010 at position 3
    send_sym(3'b111);
    send_range(0, 0);
    w0 = wr_cnt;
    send_range(1, 2);
    send_sym(3'b010);
    chk("bad_code_err", err, 1);
    chk("bad_code_no_wr", wr_en, 0);
    chk("bad_code_writes", wr_cnt - w0, 2);

    // Reset mid-frame at bit_idx 22
    send_sym(3'b111);
    send_range(0, 21);
    chk("pre_rst_bit_idx", bit_idx, 22);
    chk("pre_rst_dir", dir, 4);
    @(negedge clk);
    hrd_rst = 1'b1;
    @(negedge clk);
    hrd_rst = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_bit_idx", bit_idx, 0);
    chk("mid_rst_dir", dir, 15);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    w0 = wr_cnt;
    send_range(22, 40);
    chk("post_rst_no_writes", wr_cnt - w0, 0);
    send_sym(3'b111);
    send_range(0, 1);
    chk("relock_writes", wr_cnt - w0, 1);

    // Enable drops together with the symbol at position 30
    send_range(2, 29);
    chk("pre_en_bit_idx", bit_idx, 30);
    w0 = wr_cnt;
    @(negedge clk);
    sym_valid = 1'b1;
    irig_data = sym_at(30);
    en        = 1'b0;
    @(negedge clk);
    sym_valid = 1'b0;
    irig_data = 3'b000;
    chk("en_drop_state", state, 0);
    chk("en_drop_wr_en", wr_en, 0);
    chk("en_drop_dir", dir, 15);
    chk("en_drop_in_frame", in_frame, 0);
    chk("en_drop_bit_idx", bit_idx, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_resume_hunt", state, 1);
    chk("en_drop_writes", wr_cnt - w0, 0);

    // 256 back-to-back frames wrap the counter
    send_sym(3'b111);
    d0 = done_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 256; k++) begin
      send_range(0, 99);
      if (k == 0)   chk("wrap_cnt_first", frame_cnt, 1);
      if (k == 254) chk("wrap_cnt_255", frame_cnt, 255);
    end
    chk("wrap_cnt_zero", frame_cnt, 0);
    chk("wrap_done_pulses", done_cnt - d0, 256);
    chk("wrap_no_errs", err_cnt - e0, 0);

    chk("stray_pulses", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
